// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared gate-FSM state encoding and sizing constants for the
//            multi-gate parking lot occupancy counter.
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int MAX_GATES = 8;

    typedef enum logic [2:0] {
        GS_IDLE  = 3'd0,
        GS_EN_A  = 3'd1,
        GS_EN_AB = 3'd2,
        GS_EN_B  = 3'd3,
        GS_EX_B  = 3'd4,
        GS_EX_AB = 3'd5,
        GS_EX_A  = 3'd6
    } gate_state_t;

    // Number of set bits in a gate vector; at most MAX_GATES, so 4 bits suffice.
    function automatic logic [3:0] popcount_gates(input logic [MAX_GATES-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < MAX_GATES; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_gate_fsm.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_fsm
// Purpose  : One gate's a/b sensor sequencer; strobes done_enter/done_exit
//            combinationally on the edge that completes a passage.
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_fsm
    import parking_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic done_enter,
    output logic done_exit
);

    gate_state_t r_state;
    gate_state_t w_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= GS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Exit states mirror the entry states with the roles of a and b swapped.
    always_comb begin
        w_next     = r_state;
        done_enter = 1'b0;
        done_exit  = 1'b0;
        case (r_state)
            GS_IDLE: begin
                if (a && !b)      w_next = GS_EN_A;
                else if (!a && b) w_next = GS_EX_B;
            end
            GS_EN_A: begin
                if (!a)     w_next = GS_IDLE;
                else if (b) w_next = GS_EN_AB;
            end
            GS_EN_AB: begin
                case ({a, b})
                    2'b00:   w_next = GS_IDLE;
                    2'b01:   w_next = GS_EN_B;
                    2'b10:   w_next = GS_EN_A;
                    default: w_next = GS_EN_AB;
                endcase
            end
            GS_EN_B: begin
                if (!a && !b) begin
                    w_next     = GS_IDLE;
                    done_enter = 1'b1;
                end else if (a) begin
                    w_next = GS_EN_AB;
                end
            end
            GS_EX_B: begin
                if (!b)     w_next = GS_IDLE;
                else if (a) w_next = GS_EX_AB;
            end
            GS_EX_AB: begin
                case ({a, b})
                    2'b00:   w_next = GS_IDLE;
                    2'b10:   w_next = GS_EX_A;
                    2'b01:   w_next = GS_EX_B;
                    default: w_next = GS_EX_AB;
                endcase
            end
            GS_EX_A: begin
                if (!a && !b) begin
                    w_next    = GS_IDLE;
                    done_exit = 1'b1;
                end else if (b) begin
                    w_next = GS_EX_AB;
                end
            end
            default: w_next = GS_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/parking_lot_multi.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_multi
// Purpose  : Multi-gate parking lot occupancy counter with saturating count,
//            per-gate entry/exit pulses and overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module parking_lot_multi
    import parking_pkg::*;
#(
    parameter int N_GATES  = 2,
    parameter int CAPACITY = 25,
    parameter int CW       = $clog2(CAPACITY + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_GATES-1:0] a,
    input  logic [N_GATES-1:0] b,
    output logic [N_GATES-1:0] enter,
    output logic [N_GATES-1:0] exit,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               underflow
);

    localparam int SW = CW + 4;

    logic [N_GATES-1:0]   w_done_enter;
    logic [N_GATES-1:0]   w_done_exit;
    logic [MAX_GATES-1:0] w_enter_vec;
    logic [MAX_GATES-1:0] w_exit_vec;
    logic [3:0]           w_n_enter;
    logic [3:0]           w_n_exit;
    logic signed [SW-1:0] w_sum;
    logic [CW-1:0]        w_next_count;
    logic                 w_ovf;
    logic                 w_unf;

    logic [N_GATES-1:0]   r_enter;
    logic [N_GATES-1:0]   r_exit;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic                 r_unf;

    generate
        for (genvar gi = 0; gi < N_GATES; gi++) begin : g_gate
            parking_gate_fsm u_gate (
                .clock      (clock),
                .reset      (reset),
                .a          (a[gi]),
                .b          (b[gi]),
                .done_enter (w_done_enter[gi]),
                .done_exit  (w_done_exit[gi])
            );
        end
    endgenerate

    // Entries and exits are netted first, then the result is saturated.
    always_comb begin
        w_enter_vec                = '0;
        w_exit_vec                 = '0;
        w_enter_vec[N_GATES-1:0]   = w_done_enter;
        w_exit_vec[N_GATES-1:0]    = w_done_exit;
        w_n_enter                  = popcount_gates(w_enter_vec);
        w_n_exit                   = popcount_gates(w_exit_vec);
        w_sum = $signed({4'b0000, r_count})
              + $signed({{(SW-4){1'b0}}, w_n_enter})
              - $signed({{(SW-4){1'b0}}, w_n_exit});
        w_next_count = w_sum[CW-1:0];
        w_ovf        = 1'b0;
        w_unf        = 1'b0;
        if (w_sum[SW-1]) begin
            w_next_count = '0;
            w_unf        = 1'b1;
        end else if (w_sum > $signed(SW'(CAPACITY))) begin
            w_next_count = CW'(CAPACITY);
            w_ovf        = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_enter <= '0;
            r_exit  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_enter <= w_done_enter;
            r_exit  <= w_done_exit;
            r_count <= w_next_count;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end
    end

    assign enter     = r_enter;
    assign exit      = r_exit;
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign full      = (r_count == CW'(CAPACITY));
    assign empty     = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_lot_multi
// Purpose  : Self-checking bench: directed passages plus random sensor
//            traffic against a passage-tracking reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_lot_multi;

    localparam int NG  = 2;
    localparam int CAP = 2;
    localparam int CW  = $clog2(CAP + 1);

    logic          clock;
    logic          reset;
    logic [NG-1:0] a;
    logic [NG-1:0] b;
    logic [NG-1:0] enter;
    logic [NG-1:0] exit;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each gate is either idle or part-way along a passage
    // (direction +1 entering / -1 exiting, stage 1..3 along the sensor pair).
    int            m_dir   [NG];
    int            m_stage [NG];
    int            m_count;
    logic [NG-1:0] m_enter;
    logic [NG-1:0] m_exit;
    logic          m_ovf;
    logic          m_unf;

    parking_lot_multi #(
        .N_GATES  (NG),
        .CAPACITY (CAP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .enter     (enter),
        .exit      (exit),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int stage_of(input int dir, input logic av, input logic bv);
        if (!av && !bv) return 0;
        if (av && bv)   return 2;
        if (dir > 0)    return av ? 1 : 3;
        return bv ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NG; g++) begin
            m_dir[g]   = 0;
            m_stage[g] = 0;
        end
        m_count = 0;
        m_enter = '0;
        m_exit  = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_edge(input logic [NG-1:0] av, input logic [NG-1:0] bv);
        int nc;
        int k;
        m_enter = '0;
        m_exit  = '0;
        for (int g = 0; g < NG; g++) begin
            if (m_dir[g] == 0) begin
                if (av[g] && !bv[g])      begin m_dir[g] = 1;  m_stage[g] = 1; end
                else if (!av[g] && bv[g]) begin m_dir[g] = -1; m_stage[g] = 1; end
            end else begin
                k = stage_of(m_dir[g], av[g], bv[g]);
                if (k == 0) begin
                    if (m_stage[g] == 3) begin
                        if (m_dir[g] > 0) m_enter[g] = 1'b1;
                        else              m_exit[g]  = 1'b1;
                    end
                    m_dir[g] = 0;
                end else if (m_stage[g] == 1 && k == 3) begin
                    m_dir[g] = 0;
                end else if (m_stage[g] == 3 && k == 1) begin
                    m_stage[g] = 2;
                end else begin
                    m_stage[g] = k;
                end
            end
        end
        nc = m_count + $countones(m_enter) - $countones(m_exit);
        m_ovf = (nc > CAP);
        m_unf = (nc < 0);
        m_count = m_ovf ? CAP : (m_unf ? 0 : nc);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".enter"},     32'(enter),     32'(m_enter));
        check({tag, ".exit"},      32'(exit),      32'(m_exit));
        check({tag, ".count"},     32'(count),     32'(m_count));
        check({tag, ".full"},      32'(full),      32'(m_count == CAP));
        check({tag, ".empty"},     32'(empty),     32'(m_count == 0));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic cycle(input string tag, input logic [NG-1:0] av, input logic [NG-1:0] bv);
        @(negedge clock);
        a = av;
        b = bv;
        @(posedge clock);
        model_edge(av, bv);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a     = '0;
        b     = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Gate0 entry: a/b = 10,11,01,00
        cycle("s1a", 2'b01, 2'b00);
        cycle("s1b", 2'b01, 2'b01);
        cycle("s1c", 2'b00, 2'b01);
        cycle("s1d", 2'b00, 2'b00);
        check("s1.count_const", 32'(count), 32'd1);
        check("s1.enter_const", 32'(enter), 32'd1);
        cycle("s1e", 2'b00, 2'b00);

        // Gate1 exit: a/b = 01,11,10,00
        cycle("s2a", 2'b00, 2'b10);
        cycle("s2b", 2'b10, 2'b10);
        cycle("s2c", 2'b10, 2'b00);
        cycle("s2d", 2'b00, 2'b00);
        check("s2.exit_const", 32'(exit), 32'd2);
        check("s2.empty_const", 32'(empty), 32'd1);

        // Gate0 abort: a/b = 10,11,10,00
        cycle("s3a", 2'b01, 2'b00);
        cycle("s3b", 2'b01, 2'b01);
        cycle("s3c", 2'b01, 2'b00);
        cycle("s3d", 2'b00, 2'b00);
        check("s3.count_const", 32'(count), 32'd0);

        // One entry, then two simultaneous entries past capacity
        cycle("s4a", 2'b01, 2'b00);
        cycle("s4b", 2'b01, 2'b01);
        cycle("s4c", 2'b00, 2'b01);
        cycle("s4d", 2'b00, 2'b00);
        cycle("s4e", 2'b11, 2'b00);
        cycle("s4f", 2'b11, 2'b11);
        cycle("s4g", 2'b00, 2'b11);
        cycle("s4h", 2'b00, 2'b00);
        check("s4.count_const", 32'(count), 32'(CAP));
        check("s4.overflow_const", 32'(overflow), 32'd1);
        cycle("s4i", 2'b00, 2'b00);

        // Entry on gate0 and exit on gate1 netted at capacity
        cycle("s5a", 2'b01, 2'b10);
        cycle("s5b", 2'b11, 2'b11);
        cycle("s5c", 2'b10, 2'b01);
        cycle("s5d", 2'b00, 2'b00);
        check("s5.count_const", 32'(count), 32'(CAP));
        check("s5.overflow_const", 32'(overflow), 32'd0);

        // Exit at empty
        async_reset("s6rst");
        cycle("s6a", 2'b00, 2'b01);
        cycle("s6b", 2'b01, 2'b01);
        cycle("s6c", 2'b01, 2'b00);
        cycle("s6d", 2'b00, 2'b00);
        check("s6.underflow_const", 32'(underflow), 32'd1);
        cycle("s6e", 2'b00, 2'b00);

        // Reset in the middle of an entry, then the tail of that passage
        cycle("s7a", 2'b01, 2'b00);
        cycle("s7b", 2'b01, 2'b01);
        async_reset("s7rst");
        cycle("s7c", 2'b00, 2'b01);
        cycle("s7d", 2'b00, 2'b00);
        cycle("s7e", 2'b00, 2'b00);

        for (int i = 0; i < 600; i++) begin
            cycle("rnd", NG'($urandom), NG'($urandom));
            if ($urandom_range(0, 99) < 2) async_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parking_lot_multi.md
PARKING_LOT_MULTI -- requirements
Module: parking_lot_multi

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- N_GATES, 2, number of independent gates, each with one a/b sensor pair; range 1..8
- CAPACITY, 25, maximum occupancy; range 1..255
- CW, $clog2(CAPACITY+1), count width (derived, not overridden)
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clock, in, 1, sole clock; all state on posedge
- reset, in, 1, asynchronous, active-high
- a, in, N_GATES, outer sensor per gate, 1 = blocked; synchronous to clock
- b, in, N_GATES, inner sensor per gate, 1 = blocked; synchronous to clock
- enter, out, N_GATES, one-cycle pulse per completed entry at gate i
- exit, out, N_GATES, one-cycle pulse per completed exit at gate i
- count, out, CW, current occupancy, registered
- full, out, 1, count == CAPACITY
- empty, out, 1, count == 0
- overflow, out, 1, one-cycle pulse: entries were clipped at CAPACITY
- underflow, out, 1, one-cycle pulse: exits were clipped at 0
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-high, ports named clock and reset.

Function
REQ-004 Each gate SHALL run an independent 7-state FSM: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A.
REQ-005 Transitions for IDLE: a&!b -> EN_A; !a&b -> EX_B; otherwise (including a&b) stay.
REQ-006 Transitions for EN_A: !a -> IDLE; a&b -> EN_AB; otherwise stay.
REQ-007 Transitions for EN_AB: !a&!b -> IDLE (abort); !a&b -> EN_B; a&!b -> EN_A; a&b -> stay.
REQ-008 Transitions for EN_B: !a&!b -> IDLE and entry completes; a -> EN_AB; otherwise stay.
REQ-009 Exit path SHALL mirror entry with a and b swapped: EX_B/EX_AB/EX_A; completion is EX_A with !a&!b -> IDLE.
REQ-010 Completion SHALL register enter[i]/exit[i] high for exactly the one cycle following the completing edge; enter and exit SHALL never both be high for the same gate.
REQ-011 Occupancy SHALL update on the same edge that raises the pulses: next = count + popcount(entries) - popcount(exits), computed signed at CW+4 bits.
REQ-012 When next > CAPACITY, count SHALL saturate at CAPACITY and overflow SHALL pulse for one cycle; when next < 0, count SHALL saturate at 0 and underflow SHALL pulse.
REQ-013 Simultaneous entries and exits on different gates SHALL be netted before saturation; e.g. count=CAPACITY with 1 entry and 1 exit gives count unchanged and no overflow.
REQ-014 full and empty SHALL be combinational decodes of the count register.
REQ-015 Gate FSMs SHALL be unaffected by count state; entry still completes when full (overflow flags it).

Reset
REQ-016 While reset is high, all FSMs SHALL be IDLE and all outputs 0 except empty=1, count=0; this SHALL take effect immediately, independent of clock.
REQ-017 Reset asserted mid-sequence SHALL discard partial passages; after release each gate SHALL require a fresh sequence from IDLE.

Structure
REQ-018 Package parking_pkg SHALL hold the gate_state_t enum and the MAX_GATES=8 constant.
REQ-019 Sub-module parking_gate_fsm SHALL implement one gate (a, b in; done_enter, done_exit out), instantiated N_GATES times by generate loop; counting and saturation SHALL reside in the top level.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then gate0 a/b = 10,11,01,00 -> enter[0] one pulse; count=1; empty 1->0
- Gate1 a/b = 01,11,10,00 starting at count=1 -> exit[1] pulse; count=0; empty=1
- Gate0 a/b = 10,11,10,00 (abort) -> no pulse; count unchanged
- N_GATES=2, CAPACITY=2: three entries, last two completing on the same edge from count=1 -> count=2, full=1, overflow one pulse
- Entry on gate0 and exit on gate1 completing on the same edge at count=CAPACITY -> count unchanged, no overflow
- Exit at count=0 -> count=0, underflow one pulse; reset asserted mid-EN_AB -> count=0, FSM IDLE, no enter pulse after release
